alu_arbiter_sequencer: RTL and testbench

Shares the single ALU datapath between two requesters: port 0 is the control unit and port 1 is the debug/test port. Arbitration is round-robin. The block latches the granted operation's operands and opcode and drives them to the ALU. It holds them for an opcode-dependent number of cycles, so multiply and divide get a multicycle path, then captures the 64-bit result into HI/LO and returns it with a valid/ready handshake. Each instance sits between the requesters and one ALU.

---
 rtl/alu_arbiter_sequencer_if.sv | 20 ++
 rtl/alu_arbiter_sequencer.sv | 118 +++++++++++
 tb/tb_alu_arbiter_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_sequencer_if.sv
// alu_arbiter_sequencer_if: requester, ALU and response signals around the shared ALU
interface alu_arbiter_sequencer_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_opcode, req1_opcode, alu_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, rsp_hi, rsp_lo;
  logic [63:0] alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b, req1_valid, req1_opcode, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_hi, rsp_lo,
    input  rsp_err, busy
  );
  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b, req1_valid, req1_opcode, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_hi, rsp_lo,
    output rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter_sequencer.sv
// alu_arbiter_sequencer: round-robin sharing of one ALU with multicycle hold and HI/LO response
module alu_arbiter_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input logic                    clock,
  input logic                    clear,
  alu_arbiter_sequencer_if.slave bus
);
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d, rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       alu_opcode_q, alu_opcode_d, op_in;
  logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
  logic [31:0]      a_in, b_in;
  logic             gnt0, gnt1, fault;

  function automatic logic bad_op(input logic [4:0] op, input logic [31:0] b);
    return !(op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                        5'b01010, 5'b01011, OP_MUL, OP_DIV, 5'b10001, 5'b10010})
           || (op == OP_DIV && b == '0);
  endfunction

  // faulting operations take the single-cycle path regardless of opcode
  function automatic logic [CNT_W-1:0] cnt_load(input logic [4:0] op, input logic [31:0] b);
    return bad_op(op, b) ? '0 :
           op == OP_MUL  ? CNT_W'(MUL_CYCLES - 1) :
           op == OP_DIV  ? CNT_W'(DIV_CYCLES - 1) : '0;
  endfunction

  assign gnt0  = state_q == IDLE && bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign gnt1  = state_q == IDLE && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
  assign op_in = gnt1 ? bus.req1_opcode : bus.req0_opcode;
  assign a_in  = gnt1 ? bus.req1_a : bus.req0_a;
  assign b_in  = gnt1 ? bus.req1_b : bus.req0_b;
  assign fault = bad_op(alu_opcode_q, alu_b_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_hi_d     = rsp_hi_q;
    rsp_lo_d     = rsp_lo_q;
    if (gnt0 || gnt1) begin
      alu_opcode_d = op_in;
      alu_a_d      = a_in;
      alu_b_d      = b_in;
      rsp_id_d     = gnt1;
      last_grant_d = gnt1;
      rsp_err_d    = 1'b0;
      cnt_d        = cnt_load(op_in, b_in);
      state_d      = EXEC;
    end else if (state_q == EXEC && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == EXEC) begin
      rsp_hi_d    = fault ? '0 : bus.alu_result[63:32];
      rsp_lo_d    = fault ? '0 : bus.alu_result[31:0];
      rsp_err_d   = fault;
      rsp_valid_d = 1'b1;
      state_d     = RESP;
    end else if (state_q == RESP && bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
      alu_opcode_d = '0;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_hi_q     <= '0;
      rsp_lo_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_hi_q     <= rsp_hi_d;
      rsp_lo_q     <= rsp_lo_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_hi     = rsp_hi_q;
  assign bus.rsp_lo     = rsp_lo_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter_sequencer.sv
// tb_alu_arbiter_sequencer: directed stimulus with a response scoreboard and a behavioural ALU
module tb_alu_arbiter_sequencer;
  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND = 5'b00101;
  localparam logic [4:0] MUL = 5'b01111, DIV = 5'b10000, ILL = 5'b11111;
  typedef struct packed {logic id; logic [31:0] hi; logic [31:0] lo; logic err;} exp_t;

  logic clock, clear;
  int   tests, fails;
  exp_t sb[$];

  alu_arbiter_sequencer_if bus();
  alu_arbiter_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8), .CNT_W(4)) dut (
    .clock(clock), .clear(clear), .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // divide by zero returns junk so that the forced zero capture is visible
  always_comb begin
    case (bus.alu_opcode)
      ADD:     bus.alu_result = {32'h0, bus.alu_a + bus.alu_b};
      SUB:     bus.alu_result = {32'h0, bus.alu_a - bus.alu_b};
      AND:     bus.alu_result = {32'h0, bus.alu_a & bus.alu_b};
      MUL:     bus.alu_result = {32'h0, bus.alu_a} * {32'h0, bus.alu_b};
      DIV:     bus.alu_result = bus.alu_b == 0 ? 64'hDEAD_BEEF_DEAD_BEEF
                                : {bus.alu_a % bus.alu_b, bus.alu_a / bus.alu_b};
      default: bus.alu_result = {bus.alu_a, bus.alu_b};
    endcase
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit p, input logic v, input logic [4:0] op, input logic [31:0] a, b);
    if (p) begin
      bus.req1_valid = v; bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic issue(input bit p, input logic [4:0] op, input logic [31:0] a, b, eh, el,
                       input bit ee, input int lat);
    int n;
    drive(p, 1'b1, op, a, b);
    n = 0;
    @(negedge clock);
    while (!(p ? bus.req1_ready : bus.req0_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("grant_seen", n < 50, 1);
    sb.push_back(exp_t'{p, eh, el, ee});
    @(posedge clock); #1;
    drive(p, 1'b0, 5'h0, 32'h0, 32'h0);
    chk("err_clear_on_accept", bus.rsp_err, 0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      chk("alu_hold", {bus.alu_opcode, bus.alu_a, bus.alu_b}, {op, a, b});
      @(posedge clock); #1;
      n++;
    end
    chk("latency", n, lat);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (clear) begin
        chk("one_ready_idle_only", (bus.req0_ready && bus.req1_ready) ||
            (bus.busy && (bus.req0_ready || bus.req1_ready)), 0);
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_id", bus.rsp_id, e.id);
            chk("rsp_hi", bus.rsp_hi, e.hi);
            chk("rsp_lo", bus.rsp_lo, e.lo);
            chk("rsp_err", bus.rsp_err, e.err);
          end
        end
      end
    end
  end

  initial begin
    int n;
    bit g;
    tests = 0;
    fails = 0;
    clear = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(0, 1'b0, 5'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 5'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_hi, bus.rsp_lo}, 0);
    chk("reset_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b}, 0);
    chk("reset_busy_ready", {bus.busy, bus.req0_ready, bus.req1_ready}, 0);
    clear = 1'b1;

    issue(0, ADD, 32'd5, 32'd7, 32'h0, 32'd12, 1'b0, 1);
    @(posedge clock); #1;
    issue(1, MUL, 32'h10000, 32'h10000, 32'h1, 32'h0, 1'b0, 4);
    @(posedge clock); #1;
    issue(0, DIV, 32'd9, 32'd0, 32'h0, 32'h0, 1'b1, 1);
    @(posedge clock); #1;
    issue(0, DIV, 32'd9, 32'd2, 32'h1, 32'h4, 1'b0, 8);
    @(posedge clock); #1;

    bus.rsp_ready = 1'b0;
    issue(0, ADD, 32'd100, 32'd23, 32'h0, 32'd123, 1'b0, 1);
    drive(1, 1'b1, AND, 32'hF0, 32'h3C);
    repeat (10) begin
      @(negedge clock);
      chk("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_hi, bus.rsp_lo}, {1'b1, 1'b0, 32'h0, 32'd123});
      chk("bp_no_grant", bus.req1_ready, 0);
    end
    @(posedge clock); #1;
    bus.rsp_ready = 1'b1;
    sb.push_back(exp_t'{1'b1, 32'h0, 32'h30, 1'b0});
    @(negedge clock);
    chk("bp_no_grant_on_rsp", bus.req1_ready, 0);
    @(negedge clock);
    chk("bp_grant_next", bus.req1_ready, 1);
    @(posedge clock); #1;
    drive(1, 1'b0, 5'h0, 32'h0, 32'h0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("bp_rsp_seen", n < 50, 1);
    @(posedge clock); #1;

    drive(1, 1'b1, MUL, 32'd3, 32'd4);
    n = 0;
    @(negedge clock);
    while (!bus.req1_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1;
    drive(1, 1'b0, 5'h0, 32'h0, 32'h0);
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    chk("midreset_idle", {bus.busy, bus.rsp_valid, bus.alu_opcode}, 0);
    repeat (6) @(posedge clock);
    #1;
    chk("midreset_no_rsp", bus.rsp_valid, 0);
    issue(1, ILL, 32'd3, 32'd3, 32'h0, 32'h0, 1'b1, 1);
    @(posedge clock); #1;

    clear = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    drive(0, 1'b1, ADD, 32'd1, 32'd2);
    drive(1, 1'b1, SUB, 32'd10, 32'd4);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clock);
      while (!(bus.req0_ready || bus.req1_ready) && n < 50) begin
        @(negedge clock);
        n++;
      end
      g = bus.req1_ready;
      chk("rr_grant", g, k % 2);
      if (k > 0) chk("rr_gap", n, 2);
      sb.push_back(g ? exp_t'{1'b1, 32'h0, 32'h6, 1'b0} : exp_t'{1'b0, 32'h0, 32'h3, 1'b0});
      @(posedge clock); #1;
    end
    drive(0, 1'b0, 5'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 5'h0, 32'h0, 32'h0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
